// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with direct and counted-burst operation
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);
  logic [CW-1:0]    steps;
  logic [2:0]       lmode;
  logic [2:0]       sel;
  logic [WIDTH-1:0] nxt;
  assign sout_r = pout[0];
  assign sout_l = pout[WIDTH-1];
  assign sel = busy ? lmode : mode;
  // next register value for the active operation; hold and reserved keep pout
  always_comb begin
    nxt = pout;
    case (sel)
      3'b001: nxt = {sin_r, pout[WIDTH-1:1]};
      3'b010: nxt = {pout[WIDTH-2:0], sin_l};
      3'b011: nxt = pin;
      3'b100: nxt = {pout[0], pout[WIDTH-1:1]};
      3'b101: nxt = {pout[WIDTH-2:0], pout[WIDTH-1]};
      3'b110: nxt = {pout[WIDTH-1], pout[WIDTH-1:1]};
      default: nxt = pout;
    endcase
  end
  // register, burst counter and status; done always falls after one cycle regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout  <= RST_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
      steps <= '0;
      lmode <= 3'b000;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (busy) begin
          pout  <= nxt;
          steps <= steps - CW'(1);
          if (steps == CW'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else if (start) begin
          lmode <= mode;
          steps <= cnt;
          busy  <= (cnt != '0);
          done  <= (cnt == '0);
        end else begin
          pout <= nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: vector-table and scoreboard bench for univ_shift_reg (WIDTH=4, CW=3)
module tb_univ_shift_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = '0;
  logic [3:0] pin = '0;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cnt = '0;
  logic [3:0] pout;
  logic       sout_r, sout_l, busy, done;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic [3:0] pin;
    logic       sr;
    logic       sl;
    logic       start;
    logic [2:0] cnt;
    logic [3:0] ep;
    logic       eb;
    logic       ed;
  } vec_t;

  typedef struct packed {
    logic [3:0] p;
    logic       b;
    logic       d;
  } exp_t;

  vec_t t1[$];
  vec_t t2[$];
  vec_t t3[$];
  exp_t sb[$];

  univ_shift_reg #(.WIDTH(4), .CW(3), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pin(pin),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .cnt(cnt),
    .pout(pout), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [2:0] m, logic [3:0] p, logic r, logic l,
                              logic s, logic [2:0] c, logic [3:0] ep, logic eb, logic ed);
    return '{e, m, p, r, l, s, c, ep, eb, ed};
  endfunction

  task automatic check(string name, int idx, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
    end
  endtask

  task automatic check_now(string name, int idx, exp_t e);
    check({name, ".pout"}, idx, pout, e.p);
    check({name, ".busy"}, idx, {3'b0, busy}, {3'b0, e.b});
    check({name, ".done"}, idx, {3'b0, done}, {3'b0, e.d});
    check({name, ".sout_r"}, idx, {3'b0, sout_r}, {3'b0, e.p[0]});
    check({name, ".sout_l"}, idx, {3'b0, sout_l}, {3'b0, e.p[3]});
  endtask

  task automatic apply(string name, int idx, vec_t v);
    exp_t e;
    en = v.en; mode = v.mode; pin = v.pin; sin_r = v.sr; sin_l = v.sl;
    start = v.start; cnt = v.cnt;
    sb.push_back('{v.ep, v.eb, v.ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_now(name, idx, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and load
    t1.push_back(mk(1, 3'b011, 4'b1111, 0, 0, 0, 0, 4'b1111, 0, 0));
    // direct operations
    t2.push_back(mk(1, 3'b011, 4'b1011, 0, 0, 0, 0, 4'b1011, 0, 0));
    t2.push_back(mk(1, 3'b001, 4'b0000, 0, 0, 0, 0, 4'b0101, 0, 0));
    t2.push_back(mk(1, 3'b010, 4'b0000, 0, 1, 0, 0, 4'b1011, 0, 0));
    t2.push_back(mk(1, 3'b011, 4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0));
    t2.push_back(mk(1, 3'b110, 4'b0000, 0, 0, 0, 0, 4'b1100, 0, 0));
    t2.push_back(mk(1, 3'b011, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(1, 3'b100, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0));
    t2.push_back(mk(1, 3'b101, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(1, 3'b111, 4'b1110, 1, 1, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(1, 3'b000, 4'b1110, 1, 1, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(0, 3'b011, 4'b1111, 0, 0, 0, 0, 4'b0001, 0, 0));
    // burst rotate, mode input toggled while busy
    t2.push_back(mk(1, 3'b011, 4'b0011, 0, 0, 0, 0, 4'b0011, 0, 0));
    t2.push_back(mk(1, 3'b100, 4'b0000, 0, 0, 1, 3, 4'b0011, 1, 0));
    t2.push_back(mk(1, 3'b010, 4'b0000, 0, 1, 0, 0, 4'b1001, 1, 0));
    t2.push_back(mk(1, 3'b011, 4'b1111, 0, 0, 0, 0, 4'b1100, 1, 0));
    t2.push_back(mk(1, 3'b001, 4'b0000, 1, 0, 0, 0, 4'b0110, 0, 1));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0110, 0, 0));
    // zero-length burst
    t2.push_back(mk(1, 3'b001, 4'b0000, 0, 0, 1, 0, 4'b0110, 0, 1));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0110, 0, 0));
    // start during busy dropped, including on the finishing edge
    t2.push_back(mk(1, 3'b101, 4'b0000, 0, 0, 1, 2, 4'b0110, 1, 0));
    t2.push_back(mk(1, 3'b011, 4'b1111, 0, 0, 1, 5, 4'b1100, 1, 0));
    t2.push_back(mk(1, 3'b011, 4'b1111, 0, 0, 1, 5, 4'b1001, 0, 1));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b1001, 0, 0));
    // stall with en low mid-burst; done not stretched by en
    t2.push_back(mk(1, 3'b011, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(1, 3'b010, 4'b0000, 0, 0, 1, 4, 4'b0001, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0010, 1, 0));
    t2.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0010, 1, 0));
    t2.push_back(mk(0, 3'b011, 4'b1111, 0, 0, 1, 1, 4'b0010, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b1000, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 1));
    t2.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    // burst to be aborted by reset after the second step
    t2.push_back(mk(1, 3'b011, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, 0));
    t2.push_back(mk(1, 3'b010, 4'b0000, 0, 0, 1, 4, 4'b0001, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0010, 1, 0));
    t2.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    // after abort: no done; back-to-back bursts; burst LOAD
    t3.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    t3.push_back(mk(1, 3'b011, 4'b0011, 0, 0, 0, 0, 4'b0011, 0, 0));
    t3.push_back(mk(1, 3'b100, 4'b0000, 0, 0, 1, 1, 4'b0011, 1, 0));
    t3.push_back(mk(1, 3'b100, 4'b0000, 0, 0, 1, 2, 4'b1001, 0, 1));
    t3.push_back(mk(1, 3'b101, 4'b0000, 0, 0, 1, 2, 4'b1001, 1, 0));
    t3.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0011, 1, 0));
    t3.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0110, 0, 1));
    t3.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b0110, 0, 0));
    t3.push_back(mk(1, 3'b011, 4'b1010, 0, 0, 1, 2, 4'b0110, 1, 0));
    t3.push_back(mk(1, 3'b000, 4'b0101, 0, 0, 0, 0, 4'b0101, 1, 0));
    t3.push_back(mk(1, 3'b000, 4'b1111, 0, 0, 0, 0, 4'b1111, 0, 1));
    t3.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0));

    #2;
    check_now("reset", 0, '{4'b0000, 1'b0, 1'b0});
    #10;
    rst = 1'b0;
    foreach (t1[i]) apply("load", i, t1[i]);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_rst", 0, '{4'b0000, 1'b0, 1'b0});
    #1;
    rst = 1'b0;
    foreach (t2[i]) apply("seq", i, t2[i]);
    #2;
    rst = 1'b1;
    #1;
    check_now("abort", 0, '{4'b0000, 1'b0, 1'b0});
    #1;
    rst = 1'b0;
    foreach (t3[i]) apply("b2b", i, t3[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
